mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two cache controllers, port 0 and port 1, each issuing block reads and write-backs.
- Sits between the caches' memory-side interface and the memory controller.
- Round-robin grants, one transaction at a time, with a ready/command/ready handshake to memory.
- Captures read data per port and detects a hung memory with a timeout.

Parameters:
- AWIDTH, 9, memory address width.
- DWIDTH_CPU, 32, data word width (one block per transfer).
- TOWIDTH, 8, width of the timeout counter; timeout fires after 2**TOWIDTH-1 cycles waiting.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_rd0 / req_rd1  in  1  level read request from port 0 / port 1, held until done.
- req_wr0 / req_wr1  in  1  level write request from port 0 / port 1, held until done.
- req_addr0 / req_addr1  in  AWIDTH  request address, stable while request is held.
- req_wdata0 / req_wdata1  in  DWIDTH_CPU  write data, stable while request is held.
- done0 / done1  out  1  one-cycle completion pulse to the granted port.
- rdata0 / rdata1  out  DWIDTH_CPU  read data, valid in the done cycle and held after.
- err0 / err1  out  1  one-cycle pulse together with done when the transaction timed out.
- addr_mem  out  AWIDTH  address to memory.
- rd_mem / wr_mem  out  1  one-cycle command pulses to memory.
- wdata_mem  out  DWIDTH_CPU  write data to memory, held from issue until done.
- rdata_mem  in  DWIDTH_CPU  read data from memory, valid while ready_mem is high after a read.
- ready_mem  in  1  memory idle/ready.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the owning port, valid while busy.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: every output is 0. The state goes to IDLE. last_grant is set to 1, so port 0 wins the first tie. The timeout counter is 0.
- Reset mid-transaction: the transaction is abandoned. No done pulse is produced and command pulses stop immediately.
- All outputs are registered.
- Request decode: a port requests when req_rd|req_wr is high. If both rd and wr are high, write wins.
- IDLE:
  - Requires ready_mem=1 and at least one request. Otherwise stay in IDLE.
  - Winner is the only requester, or on a tie the port != last_grant.
  - Latch grant, op, address and wdata. Go to ISSUE.
- ISSUE (1 cycle):
  - rd_mem or wr_mem = 1 for exactly this cycle.
  - addr_mem and wdata_mem come from the latches.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for ready_mem=0, then go to WAIT_DONE.
  - If ready_mem stays high 2 cycles, treat that as a zero-wait memory and go straight to DONE, capturing rdata_mem.
- WAIT_DONE:
  - On ready_mem=1, capture rdata_mem into the granted port's rdata (reads only) and go to DONE.
- Timeout:
  - The counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - At 2**TOWIDTH-1, go to DONE with the error flag set.
  - rdata of the port is not updated on a timeout.
- DONE (1 cycle):
  - done<grant>=1, and err<grant>=1 if timed out.
  - last_grant <= grant. Return to IDLE.
- Requester rule: deassert the request at the clock edge that samples done high. The arbiter therefore never sees a stale request in the following IDLE cycle.
- Latency: IDLE to ISSUE is 1 cycle after the request is seen. The minimum request-to-done latency is 4 cycles with a 1-cycle-busy memory.
- Non-granted port: done, err and rdata stay unchanged and its request stays pending. Starvation is bounded by one transaction.
- Request changes while granted are ignored; the latched values are used.
- The op chosen for port p is echoed nowhere else; port p knows its own op.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE};
  - localparam OP_RD=0, OP_WR=1.
- Sub-module rr_pick2: combinational round-robin chooser with inputs req[1:0] and last, outputs valid and pick. It is reusable when the port count grows.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Single read: req_rd0=1, req_addr0=9'h0A5. Memory drops ready 1 cycle after rd_mem and raises it after 3 cycles with rdata_mem=32'hDEADBEEF. Expect:
  - one rd_mem pulse with addr_mem=9'h0A5;
  - done0 pulse;
  - rdata0=32'hDEADBEEF;
  - done1, rdata1 unchanged.
- Tie after reset: req_wr0 and req_rd1 raised in the same cycle. Expect wr_mem first with port 0's address and grant=0, then rd_mem for port 1 with grant=1. A second simultaneous pair is then served port 1 first.
- Back-to-back same port: port 1 re-requests immediately after done1 while port 0 also requests. Expect port 0 granted next.
- Write-back then refill (cache miss with dirty victim):
  - port 0 issues wr at addr 9'h1F8 with data 32'h12345678, then rd at 9'h0F8;
  - expect two distinct transactions in order;
  - wdata_mem=32'h12345678 held through the write;
  - rd and wr never asserted together.
- Timeout: ready_mem held 0 after the command. Expect done0=1 and err0=1 exactly 255 cycles after WAIT_BUSY entry, rdata0 unchanged, and the state back in IDLE.
- Reset mid-transaction: assert reset during WAIT_DONE. Expect:
  - all outputs 0 the next cycle;
  - no done pulse;
  - a fresh request after reset is served normally with port 0 priority.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Write wins when a port raises both rd and wr.
  function automatic logic pick_op(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int AWIDTH     = 9,
  parameter int DWIDTH_CPU = 32
) ();

  logic                  req_rd0, req_rd1;
  logic                  req_wr0, req_wr1;
  logic [AWIDTH-1:0]     req_addr0, req_addr1;
  logic [DWIDTH_CPU-1:0] req_wdata0, req_wdata1;
  logic                  done0, done1;
  logic [DWIDTH_CPU-1:0] rdata0, rdata1;
  logic                  err0, err1;
  logic [AWIDTH-1:0]     addr_mem;
  logic                  rd_mem, wr_mem;
  logic [DWIDTH_CPU-1:0] wdata_mem;
  logic [DWIDTH_CPU-1:0] rdata_mem;
  logic                  ready_mem;
  logic                  busy;
  logic                  grant;

  modport master (
    input  req_rd0, req_rd1, req_wr0, req_wr1,
    input  req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  rdata_mem, ready_mem,
    output done0, done1, rdata0, rdata1, err0, err1,
    output addr_mem, rd_mem, wr_mem, wdata_mem, busy, grant
  );

  modport slave (
    output req_rd0, req_rd1, req_wr0, req_wr1,
    output req_addr0, req_addr1, req_wdata0, req_wdata1,
    output rdata_mem, ready_mem,
    input  done0, done1, rdata0, rdata1, err0, err1,
    input  addr_mem, rd_mem, wr_mem, wdata_mem, busy, grant
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - two-way round-robin chooser
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between two cache controllers
// Round-robin, one transaction at a time, with a hung-memory timeout.
module mem_port_arbiter #(
  parameter int AWIDTH     = 9,
  parameter int DWIDTH_CPU = 32,
  parameter int TOWIDTH    = 8
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);
  import mem_arb_pkg::*;

  // Leaving a wait state at this count lands the counter on 2**TOWIDTH-1.
  localparam logic [TOWIDTH-1:0] TO_LAST = {{(TOWIDTH-1){1'b1}}, 1'b0};
  localparam logic [TOWIDTH-1:0] ZW_LAST = TOWIDTH'(1);

  arb_state_t            state_q, state_d;
  logic [TOWIDTH-1:0]    cnt_q, cnt_d;
  logic                  last_grant_q;
  logic                  grant_q;
  logic                  op_q;
  logic [AWIDTH-1:0]     addr_mem_q;
  logic [DWIDTH_CPU-1:0] wdata_mem_q;
  logic                  rd_mem_q, wr_mem_q;
  logic                  done0_q, done1_q, err0_q, err1_q;
  logic [DWIDTH_CPU-1:0] rdata0_q, rdata1_q;
  logic                  busy_q;

  logic                  pick_valid, pick;
  logic                  sel_op;
  logic [AWIDTH-1:0]     sel_addr;
  logic [DWIDTH_CPU-1:0] sel_wdata;
  logic                  launch, finish_ok, finish_to;

  rr_pick2 u_pick (
    .req   ({bus.req_rd1 | bus.req_wr1, bus.req_rd0 | bus.req_wr0}),
    .last  (last_grant_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_comb begin
    sel_op    = pick_op(pick ? bus.req_wr1 : bus.req_wr0);
    sel_addr  = pick ? bus.req_addr1 : bus.req_addr0;
    sel_wdata = pick ? bus.req_wdata1 : bus.req_wdata0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ready_mem && pick_valid) begin
          launch  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.ready_mem) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == ZW_LAST) begin
          // Memory never went busy: treat it as a zero-wait completion.
          finish_ok = 1'b1;
          state_d   = DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.ready_mem) begin
          finish_ok = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          finish_to = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_q         <= OP_RD;
      addr_mem_q   <= '0;
      wdata_mem_q  <= '0;
      rd_mem_q     <= 1'b0;
      wr_mem_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
      rd_mem_q <= launch && (sel_op == OP_RD);
      wr_mem_q <= launch && (sel_op == OP_WR);
      done0_q  <= (finish_ok || finish_to) && !grant_q;
      done1_q  <= (finish_ok || finish_to) && grant_q;
      err0_q   <= finish_to && !grant_q;
      err1_q   <= finish_to && grant_q;
      if (launch) begin
        grant_q     <= pick;
        op_q        <= sel_op;
        addr_mem_q  <= sel_addr;
        wdata_mem_q <= sel_wdata;
      end
      if (finish_ok && (op_q == OP_RD)) begin
        if (grant_q) rdata1_q <= bus.rdata_mem;
        else         rdata0_q <= bus.rdata_mem;
      end
      if (state_q == DONE) last_grant_q <= grant_q;
    end
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.addr_mem  = addr_mem_q;
  assign bus.rd_mem    = rd_mem_q;
  assign bus.wr_mem    = wr_mem_q;
  assign bus.wdata_mem = wdata_mem_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AWIDTH(9), .DWIDTH_CPU(32)) bus ();

  mem_port_arbiter #(.AWIDTH(9), .DWIDTH_CPU(32), .TOWIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int unsigned mem_busy  = 1;
  bit          mem_hang  = 1'b0;
  logic [31:0] mem_rdata = '0;

  int rd_cnt, wr_cnt, both_cnt, done0_cnt, done1_cnt, err0_cnt, err1_cnt;
  logic       cmd_is_wr [$];
  logic [8:0] cmd_addr  [$];
  logic       cmd_grant [$];

  // Memory: on a command, drop ready one cycle later, hold busy, then raise with data.
  initial begin
    bus.ready_mem = 1'b1;
    bus.rdata_mem = '0;
    forever begin
      @(negedge clock);
      if (!reset && (bus.rd_mem || bus.wr_mem)) begin
        if (mem_busy == 0 && !mem_hang) begin
          bus.rdata_mem = mem_rdata;
        end else begin
          @(negedge clock);
          bus.ready_mem = 1'b0;
          if (mem_hang) begin
            while (mem_hang) @(negedge clock);
          end else begin
            repeat (mem_busy) @(negedge clock);
          end
          bus.rdata_mem = mem_rdata;
          bus.ready_mem = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (bus.rd_mem) rd_cnt++;
    if (bus.wr_mem) wr_cnt++;
    if (bus.rd_mem && bus.wr_mem) both_cnt++;
    if (bus.rd_mem || bus.wr_mem) begin
      cmd_is_wr.push_back(bus.wr_mem);
      cmd_addr.push_back(bus.addr_mem);
      cmd_grant.push_back(bus.grant);
    end
    if (bus.done0) done0_cnt++;
    if (bus.done1) done1_cnt++;
    if (bus.err0) err0_cnt++;
    if (bus.err1) err1_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic clear_reqs();
    bus.req_rd0 = 1'b0; bus.req_wr0 = 1'b0; bus.req_addr0 = '0; bus.req_wdata0 = '0;
    bus.req_rd1 = 1'b0; bus.req_wr1 = 1'b0; bus.req_addr1 = '0; bus.req_wdata1 = '0;
  endtask

  // Waits for a done pulse and drops that port's request in the same cycle.
  task automatic wait_any_done(input int budget, output int port, output int cyc, output logic err);
    port = -1; cyc = 0; err = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.done0) begin
        port = 0; err = bus.err0; bus.req_rd0 = 1'b0; bus.req_wr0 = 1'b0;
        break;
      end
      if (bus.done1) begin
        port = 1; err = bus.err1; bus.req_rd1 = 1'b0; bus.req_wr1 = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.done0, bus.done1, bus.err0, bus.err1, bus.rd_mem, bus.wr_mem, bus.busy, bus.grant} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {bus.done0, bus.done1, bus.err0, bus.err1, bus.rd_mem, bus.wr_mem, bus.busy, bus.grant});
    end
    checks++;
    if (bus.addr_mem !== 9'h000 || bus.wdata_mem !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: addr %h wdata %h expected 0 0", bus.addr_mem, bus.wdata_mem);
    end
    checks++;
    if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: rdata0 %h rdata1 %h expected 0 0", bus.rdata0, bus.rdata1);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int p, c, rd0, wr0, d1;
    logic e;
    mem_busy = 3; mem_rdata = 32'hDEADBEEF;
    rd0 = rd_cnt; wr0 = wr_cnt; d1 = done1_cnt;
    @(negedge clock);
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h0A5;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL single_port: got %0d expected 0", p); end
    checks++; if (c !== 6) begin errors++; $display("FAIL single_latency: got %0d expected 6", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", e); end
    checks++;
    if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin
      errors++; $display("FAIL single_cmds: rd %0d wr %0d expected 1 0", rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (cmd_addr[$] !== 9'h0A5) begin errors++; $display("FAIL single_addr: got %h expected 0a5", cmd_addr[$]); end
    checks++;
    if (bus.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata0: got %h expected deadbeef", bus.rdata0); end
    @(negedge clock);
    checks++;
    if (bus.rdata0 !== 32'hDEADBEEF || bus.done0 !== 1'b0) begin
      errors++; $display("FAIL single_hold: rdata0 %h done0 %b expected deadbeef 0", bus.rdata0, bus.done0);
    end
    checks++;
    if (done1_cnt - d1 !== 0 || bus.rdata1 !== 32'h0) begin
      errors++; $display("FAIL single_port1_quiet: done1 %0d rdata1 %h expected 0 0", done1_cnt - d1, bus.rdata1);
    end
  endtask

  task automatic test_tie();
    int p, c, q;
    logic e;
    pulse_reset();
    mem_busy = 1; mem_rdata = 32'h55AA55AA;
    q = cmd_addr.size();
    @(negedge clock);
    bus.req_wr0 = 1'b1; bus.req_addr0 = 9'h011; bus.req_wdata0 = 32'hA0A0A0A0;
    bus.req_rd1 = 1'b1; bus.req_addr1 = 9'h122;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL tie_first: got %0d expected 0", p); end
    checks++; if (c !== 4) begin errors++; $display("FAIL tie_latency: got %0d expected 4", c); end
    checks++;
    if (cmd_is_wr[q] !== 1'b1 || cmd_addr[q] !== 9'h011 || cmd_grant[q] !== 1'b0) begin
      errors++; $display("FAIL tie_cmd0: wr %b addr %h grant %b expected 1 011 0", cmd_is_wr[q], cmd_addr[q], cmd_grant[q]);
    end
    @(negedge clock);
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h033;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 1) begin errors++; $display("FAIL tie_second: got %0d expected 1", p); end
    checks++;
    if (cmd_is_wr[q+1] !== 1'b0 || cmd_addr[q+1] !== 9'h122 || cmd_grant[q+1] !== 1'b1) begin
      errors++; $display("FAIL tie_cmd1: wr %b addr %h grant %b expected 0 122 1", cmd_is_wr[q+1], cmd_addr[q+1], cmd_grant[q+1]);
    end
    checks++;
    if (bus.rdata1 !== 32'h55AA55AA || bus.rdata0 !== 32'h0) begin
      errors++; $display("FAIL tie_rdata: rdata1 %h rdata0 %h expected 55aa55aa 0", bus.rdata1, bus.rdata0);
    end
    mem_rdata = 32'h0BADF00D;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL tie_third: got %0d expected 0", p); end
    checks++;
    if (bus.rdata0 !== 32'h0BADF00D || cmd_addr[q+2] !== 9'h033) begin
      errors++; $display("FAIL tie_third_data: rdata0 %h addr %h expected 0badf00d 033", bus.rdata0, cmd_addr[q+2]);
    end
  endtask

  task automatic test_back_to_back();
    int p, c, q;
    logic e;
    mem_busy = 1;
    q = cmd_addr.size();
    @(negedge clock);
    bus.req_rd1 = 1'b1; bus.req_addr1 = 9'h155;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 1) begin errors++; $display("FAIL b2b_first: got %0d expected 1", p); end
    @(negedge clock);
    bus.req_rd1 = 1'b1; bus.req_addr1 = 9'h166;
    bus.req_wr0 = 1'b1; bus.req_addr0 = 9'h077; bus.req_wdata0 = 32'h11112222;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL b2b_fair: got %0d expected 0", p); end
    checks++;
    if (cmd_addr[q+1] !== 9'h077 || cmd_is_wr[q+1] !== 1'b1) begin
      errors++; $display("FAIL b2b_cmd: addr %h wr %b expected 077 1", cmd_addr[q+1], cmd_is_wr[q+1]);
    end
    wait_any_done(40, p, c, e);
    checks++; if (p !== 1) begin errors++; $display("FAIL b2b_last: got %0d expected 1", p); end
  endtask

  task automatic test_writeback_refill();
    int p, c, q, held_bad;
    bit seen;
    logic e;
    mem_busy = 2; mem_rdata = 32'hCAFE0001;
    q = cmd_addr.size(); held_bad = 0; seen = 1'b0;
    @(negedge clock);
    bus.req_wr0 = 1'b1; bus.req_addr0 = 9'h1F8; bus.req_wdata0 = 32'h12345678;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.busy && bus.wdata_mem !== 32'h12345678) held_bad++;
      if (bus.done0) begin
        bus.req_wr0 = 1'b0; seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wb_done: got %b expected 1", seen); end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL wb_wdata_held: bad cycles %0d expected 0", held_bad); end
    @(negedge clock);
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h0F8;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL refill_port: got %0d expected 0", p); end
    checks++;
    if (cmd_addr.size() - q !== 2 || cmd_is_wr[q] !== 1'b1 || cmd_addr[q] !== 9'h1F8
        || cmd_is_wr[q+1] !== 1'b0 || cmd_addr[q+1] !== 9'h0F8) begin
      errors++; $display("FAIL wb_order: n %0d first %b/%h second %b/%h expected 2 1/1f8 0/0f8",
        cmd_addr.size() - q, cmd_is_wr[q], cmd_addr[q], cmd_is_wr[q+1], cmd_addr[q+1]);
    end
    checks++;
    if (bus.rdata0 !== 32'hCAFE0001) begin errors++; $display("FAIL refill_rdata0: got %h expected cafe0001", bus.rdata0); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_zero_wait();
    int p, c;
    logic e;
    mem_busy = 0; mem_rdata = 32'hFEEDFACE;
    @(negedge clock);
    bus.req_rd1 = 1'b1; bus.req_addr1 = 9'h0C3;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 1) begin errors++; $display("FAIL zw_port: got %0d expected 1", p); end
    checks++; if (c !== 4) begin errors++; $display("FAIL zw_latency: got %0d expected 4", c); end
    checks++; if (bus.rdata1 !== 32'hFEEDFACE) begin errors++; $display("FAIL zw_rdata1: got %h expected feedface", bus.rdata1); end
    mem_busy = 1;
  endtask

  task automatic test_timeout();
    int p, c, e0, e1;
    logic e;
    mem_hang = 1'b1; e0 = err0_cnt; e1 = err1_cnt;
    @(negedge clock);
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h0AA;
    wait_any_done(400, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL to_port: got %0d expected 0", p); end
    checks++; if (c !== 257) begin errors++; $display("FAIL to_latency: got %0d expected 257", c); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL to_err0: got %b expected 1", e); end
    checks++; if (bus.rdata0 !== 32'hCAFE0001) begin errors++; $display("FAIL to_rdata0: got %h expected cafe0001", bus.rdata0); end
    @(negedge clock);
    checks++;
    if ({bus.busy, bus.done0, bus.err0} !== 3'b000) begin
      errors++; $display("FAIL to_idle: busy/done0/err0 %b expected 000", {bus.busy, bus.done0, bus.err0});
    end
    checks++;
    if (err0_cnt - e0 !== 1 || err1_cnt - e1 !== 0) begin
      errors++; $display("FAIL to_err_count: err0 %0d err1 %0d expected 1 0", err0_cnt - e0, err1_cnt - e1);
    end
    mem_hang = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int p, c, d0, d1;
    logic e;
    mem_busy = 8; mem_rdata = 32'h77777777;
    @(negedge clock);
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h0B0;
    repeat (4) @(negedge clock);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b expected 1", bus.busy); end
    d0 = done0_cnt; d1 = done1_cnt;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.done0, bus.done1, bus.err0, bus.err1, bus.rd_mem, bus.wr_mem, bus.busy, bus.grant,
         bus.addr_mem, bus.wdata_mem, bus.rdata0, bus.rdata1} !== '0) begin
      errors++; $display("FAIL rm_outputs_zero: busy %b addr %h rdata0 %h expected all zero",
        bus.busy, bus.addr_mem, bus.rdata0);
    end
    clear_reqs();
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    checks++;
    if (done0_cnt - d0 !== 0 || done1_cnt - d1 !== 0) begin
      errors++; $display("FAIL rm_no_done: done0 %0d done1 %0d expected 0 0", done0_cnt - d0, done1_cnt - d1);
    end
    mem_busy = 1; mem_rdata = 32'h31415926;
    bus.req_rd0 = 1'b1; bus.req_addr0 = 9'h0D0;
    bus.req_rd1 = 1'b1; bus.req_addr1 = 9'h1D0;
    wait_any_done(40, p, c, e);
    checks++; if (p !== 0) begin errors++; $display("FAIL rm_fresh_first: got %0d expected 0", p); end
    checks++; if (bus.rdata0 !== 32'h31415926) begin errors++; $display("FAIL rm_fresh_rdata0: got %h expected 31415926", bus.rdata0); end
    wait_any_done(40, p, c, e);
    checks++; if (p !== 1) begin errors++; $display("FAIL rm_fresh_second: got %0d expected 1", p); end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_writeback_refill();
    test_zero_wait();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
